stopwatch_counter: RTL and testbench
====================================

// Module: stopwatch_counter
// PURPOSE
//  Time base and control FSM of the stopwatch. Divides mclk to a 10 ms tick, runs cascaded
//  centisecond/second/minute counters, decodes start/stop and clear buttons. Drives run, min,
//  sec, mil straight into the lap-hold/7-segment display stage downstream (lap button goes there).
// PARAMETERS
//  CLK_HZ       50_000_000  mclk frequency in Hz
//  TICK_HZ      100         count-tick rate; CLK_DIV = CLK_HZ/TICK_HZ, CLK_DIV >= 2 required
//  MIN_MAX      59          highest minute value before wrap
//  DEBOUNCE_MS  10          button stable time, used only with STOPWATCH_DEBOUNCE_EN
// PORTS
//  mclk      in   1  system clock
//  reset     in   1  reset, synchronous, active-high; clock mclk
//  b1        in   1  start/stop button, asynchronous level, active-high
//  b3        in   1  clear button, asynchronous level, active-high
//  run       out  1  1 while in RUN state
//  min       out  8  minutes, binary 0..MIN_MAX
//  sec       out  8  seconds, binary 0..59
//  mil       out  8  centiseconds, binary 0..99
//  overflow  out  1  one-cycle pulse on MIN_MAX:59.99 -> 00:00.00 wrap
// BEHAVIOUR
//  - Reset: state=IDLE, run=0, min=sec=mil=0, overflow=0, prescaler=0, sync/edge flops=0.
//  - Inputs: 2-flop synchronizer, then edge register; press = sync1 & ~prev (rising edge only).
//    Latency: b1 high before edge k -> press seen at edge k+2 -> run=1 after edge k+3.
//  - FSM (registered, one transition per cycle):
//    IDLE  --b1 press--> RUN ; b3 ignored.
//    RUN   --b1 press--> PAUSE ; b3 ignored while running.
//    PAUSE --b1 press--> RUN ; --b3 press--> IDLE (counters and prescaler cleared same edge).
//    b1 and b3 press same cycle in PAUSE: b3 wins -> IDLE. In IDLE/RUN: b1 acts, b3 dropped.
//  - Prescaler: counts 0..CLK_DIV-1 in RUN only; tick when ==CLK_DIV-1, then back to 0.
//    Held (not cleared) in PAUSE so resume keeps fractional tick; cleared on entry to IDLE.
//    First tick CLK_DIV cycles after run rises.
//  - On tick: mil+1; mil 99->0 carries sec+1; sec 59->0 carries min+1; min MIN_MAX->0 wraps all
//    to 00:00.00, overflow=1 for that cycle, FSM stays RUN.
//  - All outputs registered; min/sec/mil change only on tick or clear; never exceed ranges.
//  - reset mid-count: next edge returns everything to reset values regardless of state/buttons.
//  - Held button produces exactly one press; release produces none.
// CONFIGURATION
//  STOPWATCH_DEBOUNCE_EN defined: after synchronizer, a level is accepted only once stable for
//    DEB_CYC = DEBOUNCE_MS*CLK_HZ/1000 consecutive cycles; edge detect uses the filtered level;
//    press latency grows by DEB_CYC cycles; shorter glitches produce no press.
//  Not defined: no filter; synchronized level feeds edge detect directly (latency as above).
// STRUCTURE
//  - stopwatch_pkg.vh: state encodings ST_IDLE=2'd0, ST_RUN=2'd1, ST_PAUSE=2'd2; MIL_MAX=99,
//    SEC_MAX=59; shared with the downstream display stage.
//  - Sub-module btn_edge_det (instanced for b1, b3): synchronizer, optional debounce, press pulse.
//  - Top: FSM, prescaler, counter cascade, overflow pulse.
// TESTING  (bench uses CLK_HZ=1000, TICK_HZ=100 -> CLK_DIV=10; debounce off unless stated)
//  1 reset held 5 cycles with b1=1 -> run=0, min/sec/mil=0, no press after release of reset
//    until b1 drops and rises again.
//  2 b1 pulse (3 cycles) -> run=1 three edges later; after 10 more cycles mil=1; after 1000
//    cycles in RUN sec=1, mil=0.
//  3 preload-run to 00:59.99, one tick -> min=1, sec=0, mil=0; at 59:59.99 (MIN_MAX=59) one tick
//    -> 00:00.00, overflow high exactly 1 cycle, run stays 1.
//  4 RUN, b1 press at prescaler=4 -> PAUSE, values frozen 200 cycles; b1 press -> RUN, next
//    tick after 6 cycles (fraction preserved).
//  5 PAUSE with b1 and b3 pressed same cycle -> IDLE, all counters 0, run=0; b3 in RUN -> no
//    change.
//  6 STOPWATCH_DEBOUNCE_EN, DEBOUNCE_MS=5 (DEB_CYC=5): 3-cycle b1 glitch -> no press; 8-cycle
//    press -> run=1 after 3+5 cycles.

Source files
------------

// File: rtl/stopwatch_pkg.sv
// Shared stopwatch definitions: FSM state encodings and counter limits, also used by the display stage.
// Optional button debounce is enabled by defining STOPWATCH_DEBOUNCE_EN.
package stopwatch_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2
    } state_t;

    localparam logic [7:0] MIL_MAX = 8'd99;
    localparam logic [7:0] SEC_MAX = 8'd59;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam bit DEBOUNCE_ON = 1'b1;
`else
    localparam bit DEBOUNCE_ON = 1'b0;
`endif

    // Zero means "no filter"; when enabled, at least one cycle of stability is required.
    function automatic int deb_cycles(input int clk_hz, input int debounce_ms);
        int cyc;
        cyc = debounce_ms * clk_hz / 1000;
        if (!DEBOUNCE_ON)
            return 0;
        return (cyc < 1) ? 1 : cyc;
    endfunction

endpackage

// File: rtl/stopwatch_counter_btn_edge_det.sv
// Button front end: 2-flop synchronizer, optional stability filter, registered rising-edge press pulse.
// The filter is generated when DEB_CYC > 0, which happens only with STOPWATCH_DEBOUNCE_EN defined.
module btn_edge_det #(
    parameter int DEB_CYC = 0
) (
    input  logic mclk,
    input  logic reset,
    input  logic btn,
    output logic press
);

    logic       sync0;
    logic       sync1;
    logic       level;
    logic       prev;
    logic       armed;
    logic [1:0] fill;

    always_ff @(posedge mclk) begin
        if (reset) begin
            sync0 <= 1'b0;
            sync1 <= 1'b0;
        end else begin
            sync0 <= btn;
            sync1 <= sync0;
        end
    end

    generate
        if (DEB_CYC > 0) begin : g_debounce
            localparam int CNT_W = $clog2(DEB_CYC + 1);
            logic [CNT_W-1:0] deb_cnt;
            logic             filt;

            // Accept a new level only after it has differed from the filtered one for DEB_CYC cycles.
            always_ff @(posedge mclk) begin
                if (reset) begin
                    filt    <= 1'b0;
                    deb_cnt <= '0;
                end else if (sync1 == filt) begin
                    deb_cnt <= '0;
                end else if (deb_cnt == CNT_W'(DEB_CYC - 1)) begin
                    filt    <= sync1;
                    deb_cnt <= '0;
                end else begin
                    deb_cnt <= deb_cnt + 1'b1;
                end
            end

            assign level = filt;
        end else begin : g_direct
            assign level = sync1;
        end
    endgenerate

    // A button held through reset must be seen released before it can press, so presses arm only
    // once the synchronizer has refilled after reset and the line reads low.
    always_ff @(posedge mclk) begin
        if (reset) begin
            prev  <= 1'b0;
            armed <= 1'b0;
            fill  <= 2'b00;
            press <= 1'b0;
        end else begin
            prev  <= level;
            fill  <= {fill[0], 1'b1};
            armed <= armed | (fill[1] & ~sync1 & ~level);
            press <= level & ~prev & armed;
        end
    end

endmodule

// File: rtl/stopwatch_counter.sv
// Stopwatch time base: start/stop/clear FSM, 10 ms prescaler and min:sec.centisecond counters.
// Define STOPWATCH_DEBOUNCE_EN to filter the buttons for DEBOUNCE_MS before edge detection.
module stopwatch_counter
    import stopwatch_pkg::*;
#(
    parameter int CLK_HZ      = 50_000_000,
    parameter int TICK_HZ     = 100,
    parameter int MIN_MAX     = 59,
    parameter int DEBOUNCE_MS = 10
) (
    input  logic       mclk,
    input  logic       reset,
    input  logic       b1,
    input  logic       b3,
    output logic       run,
    output logic [7:0] min,
    output logic [7:0] sec,
    output logic [7:0] mil,
    output logic       overflow
);

    localparam int CLK_DIV = CLK_HZ / TICK_HZ;
    localparam int PRESC_W = $clog2(CLK_DIV);
    localparam int DEB_CYC = deb_cycles(CLK_HZ, DEBOUNCE_MS);

    state_t               state;
    state_t               state_next;
    logic                 b1_press;
    logic                 b3_press;
    logic                 clear;
    logic                 tick;
    logic [PRESC_W-1:0]   presc;

    btn_edge_det #(.DEB_CYC(DEB_CYC)) u_b1 (
        .mclk  (mclk),
        .reset (reset),
        .btn   (b1),
        .press (b1_press)
    );

    btn_edge_det #(.DEB_CYC(DEB_CYC)) u_b3 (
        .mclk  (mclk),
        .reset (reset),
        .btn   (b3),
        .press (b3_press)
    );

    always_ff @(posedge mclk) begin
        if (reset) begin
            state <= ST_IDLE;
            run   <= 1'b0;
        end else begin
            state <= state_next;
            run   <= (state_next == ST_RUN);
        end
    end

    // Clear only acts from PAUSE and beats a simultaneous start/stop there.
    always_comb begin
        state_next = state;
        case (state)
            ST_IDLE:  if (b1_press) state_next = ST_RUN;
            ST_RUN:   if (b1_press) state_next = ST_PAUSE;
            ST_PAUSE: begin
                if (b3_press)
                    state_next = ST_IDLE;
                else if (b1_press)
                    state_next = ST_RUN;
            end
            default:  state_next = ST_IDLE;
        endcase
    end

    assign clear = (state == ST_PAUSE) && b3_press;
    assign tick  = (state == ST_RUN) && (presc == PRESC_W'(CLK_DIV - 1));

    // Prescaler holds in PAUSE so a resume keeps the partial tick.
    always_ff @(posedge mclk) begin
        if (reset) begin
            presc    <= '0;
            mil      <= 8'd0;
            sec      <= 8'd0;
            min      <= 8'd0;
            overflow <= 1'b0;
        end else begin
            overflow <= 1'b0;
            if (clear) begin
                presc <= '0;
                mil   <= 8'd0;
                sec   <= 8'd0;
                min   <= 8'd0;
            end else if (state == ST_RUN) begin
                if (tick) begin
                    presc <= '0;
                    if (mil == MIL_MAX) begin
                        mil <= 8'd0;
                        if (sec == SEC_MAX) begin
                            sec <= 8'd0;
                            if (min == 8'(MIN_MAX)) begin
                                min      <= 8'd0;
                                overflow <= 1'b1;
                            end else begin
                                min <= min + 8'd1;
                            end
                        end else begin
                            sec <= sec + 8'd1;
                        end
                    end else begin
                        mil <= mil + 8'd1;
                    end
                end else begin
                    presc <= presc + 1'b1;
                end
            end
        end
    end

endmodule

// File: tb/tb_stopwatch_counter.sv
// Directed bench for stopwatch_counter at CLK_HZ=1000, TICK_HZ=100 (10 clocks per tick).
// With STOPWATCH_DEBOUNCE_EN defined it runs the debounce sequence (DEBOUNCE_MS=5) instead.
module tb_stopwatch_counter;

`ifdef STOPWATCH_DEBOUNCE_EN
    localparam int TB_DEB_MS = 5;
`else
    localparam int TB_DEB_MS = 10;
`endif

    logic       mclk;
    logic       reset;
    logic       b1;
    logic       b3;
    logic       run;
    logic [7:0] min;
    logic [7:0] sec;
    logic [7:0] mil;
    logic       overflow;

    int n_pass;
    int n_checks;

    stopwatch_counter #(
        .CLK_HZ      (1000),
        .TICK_HZ     (100),
        .MIN_MAX     (59),
        .DEBOUNCE_MS (TB_DEB_MS)
    ) dut (
        .mclk     (mclk),
        .reset    (reset),
        .b1       (b1),
        .b3       (b3),
        .run      (run),
        .min      (min),
        .sec      (sec),
        .mil      (mil),
        .overflow (overflow)
    );

    initial mclk = 1'b0;
    always #5 mclk = ~mclk;

    task automatic step(input int n);
        repeat (n) @(posedge mclk);
        #1;
    endtask

    task automatic check_output(input string tag, input logic [7:0] observed, input logic [7:0] expected);
        n_checks++;
        assert (observed === expected) n_pass++;
        else $error("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    endtask

    // Press held for three samples, then one more edge so the FSM has acted.
    task automatic press_b1();
        b1 = 1'b1;
        step(3);
        b1 = 1'b0;
        step(1);
    endtask

    task automatic press_b3();
        b3 = 1'b1;
        step(3);
        b3 = 1'b0;
        step(1);
    endtask

    task automatic check_time(input string tag, input logic [7:0] m, input logic [7:0] s, input logic [7:0] c);
        check_output({tag, "_min"}, min, m);
        check_output({tag, "_sec"}, sec, s);
        check_output({tag, "_mil"}, mil, c);
    endtask

    initial begin
        n_pass   = 0;
        n_checks = 0;
        reset    = 1'b1;
        b3       = 1'b0;

`ifdef STOPWATCH_DEBOUNCE_EN
        b1 = 1'b0;
        step(3);
        check_output("deb_reset_run", {7'd0, run}, 8'd0);
        reset = 1'b0;
        step(10);
        b1 = 1'b1;
        step(3);
        b1 = 1'b0;
        step(20);
        check_output("deb_glitch_run", {7'd0, run}, 8'd0);
        b1 = 1'b1;
        step(8);
        check_output("deb_press_early", {7'd0, run}, 8'd0);
        b1 = 1'b0;
        step(1);
        check_output("deb_press_run", {7'd0, run}, 8'd1);
        check_time("deb_press", 8'd0, 8'd0, 8'd0);
`else
        // Reset with b1 held: outputs idle and no press until b1 is released and pressed again.
        b1 = 1'b1;
        step(5);
        check_output("reset_run", {7'd0, run}, 8'd0);
        check_output("reset_ovf", {7'd0, overflow}, 8'd0);
        check_time("reset", 8'd0, 8'd0, 8'd0);
        reset = 1'b0;
        step(10);
        check_output("held_no_press", {7'd0, run}, 8'd0);
        b1 = 1'b0;
        step(4);

        // Start: run rises on the fourth edge after b1 goes high.
        b1 = 1'b1;
        step(3);
        check_output("start_latency", {7'd0, run}, 8'd0);
        b1 = 1'b0;
        step(1);
        check_output("start_run", {7'd0, run}, 8'd1);
        step(9);
        check_output("first_tick_early", mil, 8'd0);
        step(1);
        check_output("first_tick", mil, 8'd1);
        step(990);
        check_time("one_second", 8'd0, 8'd1, 8'd0);

        // Pause four clocks into a tick period, stay frozen, preload 00:59.99.
        press_b1();
        check_output("pause_run", {7'd0, run}, 8'd0);
        step(200);
        check_time("frozen", 8'd0, 8'd1, 8'd0);
        check_output("frozen_run", {7'd0, run}, 8'd0);
        force dut.mil = 8'd99;
        force dut.sec = 8'd59;
        force dut.min = 8'd0;
        #1;
        release dut.mil;
        release dut.sec;
        release dut.min;
        check_time("preload_a", 8'd0, 8'd59, 8'd99);

        // Resume: the remaining six clocks of the interrupted period, then the minute carry.
        press_b1();
        check_output("resume_run", {7'd0, run}, 8'd1);
        step(5);
        check_time("resume_early", 8'd0, 8'd59, 8'd99);
        step(1);
        check_time("min_carry", 8'd1, 8'd0, 8'd0);

        // Full wrap from 59:59.99.
        press_b1();
        force dut.mil = 8'd99;
        force dut.sec = 8'd59;
        force dut.min = 8'd59;
        #1;
        release dut.mil;
        release dut.sec;
        release dut.min;
        press_b1();
        step(5);
        check_output("ovf_before", {7'd0, overflow}, 8'd0);
        check_time("wrap_before", 8'd59, 8'd59, 8'd99);
        step(1);
        check_time("wrap", 8'd0, 8'd0, 8'd0);
        check_output("ovf_pulse", {7'd0, overflow}, 8'd1);
        check_output("wrap_run", {7'd0, run}, 8'd1);
        step(1);
        check_output("ovf_after", {7'd0, overflow}, 8'd0);

        // Clear is ignored while running.
        press_b3();
        check_output("b3_in_run", {7'd0, run}, 8'd1);
        step(10);
        check_time("b3_in_run", 8'd0, 8'd0, 8'd1);

        // Pause, then b1 and b3 together: clear wins.
        press_b1();
        check_time("pause_again", 8'd0, 8'd0, 8'd1);
        b1 = 1'b1;
        b3 = 1'b1;
        step(3);
        b1 = 1'b0;
        b3 = 1'b0;
        step(1);
        check_output("clear_run", {7'd0, run}, 8'd0);
        check_time("clear", 8'd0, 8'd0, 8'd0);

        // Restart after clear: prescaler must start from zero again.
        press_b1();
        check_output("restart_run", {7'd0, run}, 8'd1);
        step(9);
        check_output("restart_early", mil, 8'd0);
        step(1);
        check_output("restart_tick", mil, 8'd1);
`endif

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
